// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - core request/response and data BRAM port bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if #(
  parameter int RAM_ADDR_WIDTH = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic [RAM_ADDR_WIDTH-1:0] mem_w_addr;
  logic [31:0]               mem_w_dat;
  logic                      mem_w_enb;
  logic [3:0]                mem_byte_enb;
  logic [RAM_ADDR_WIDTH-1:0] mem_r_addr;
  logic                      mem_r_enb;
  logic [31:0]               mem_r_dat;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_dat,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb, mem_r_addr, mem_r_enb
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_dat,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb, mem_r_addr, mem_r_enb
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding RV32I load/store initiator for the data BRAM
module lsu_mem_ctrl #(
  parameter int RD_LAT         = 1,
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                off_q, off_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [31:0]               mem_w_dat_q, mem_w_dat_d;
  logic                      mem_w_enb_q, mem_w_enb_d;
  logic [3:0]                mem_byte_enb_q, mem_byte_enb_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_r_addr_q, mem_r_addr_d;
  logic                      mem_r_enb_q, mem_r_enb_d;

  logic        f3_bad, misaligned, out_of_range, req_err;
  logic [31:0] sh, ld_data;

  always_comb begin
    f3_bad       = bus.req_we ? (bus.req_funct3 > 3'd2)
                              : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = |bus.req_addr[31:RAM_ADDR_WIDTH];
    req_err      = f3_bad || misaligned || out_of_range;
  end

  // BRAM word is rotated down so the addressed lane sits at bit 0 before extension
  always_comb begin
    sh = bus.mem_r_dat >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    mem_w_addr_d   = mem_w_addr_q;
    mem_w_dat_d    = 32'd0;
    mem_w_enb_d    = 1'b0;
    mem_byte_enb_d = 4'd0;
    mem_r_addr_d   = mem_r_addr_q;
    mem_r_enb_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          funct3_d    = bus.req_funct3;
          off_d       = bus.req_addr[1:0];
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (bus.req_we) begin
            state_d      = S_WRITE;
            mem_w_enb_d  = 1'b1;
            mem_w_addr_d = bus.req_addr[RAM_ADDR_WIDTH-1:0];
            case (bus.req_funct3[1:0])
              2'b00: begin
                mem_byte_enb_d = 4'b0001 << bus.req_addr[1:0];
                mem_w_dat_d    = {4{bus.req_wdata[7:0]}};
              end
              2'b01: begin
                mem_byte_enb_d = 4'b0011 << bus.req_addr[1:0];
                mem_w_dat_d    = {2{bus.req_wdata[15:0]}};
              end
              default: begin
                mem_byte_enb_d = 4'b1111;
                mem_w_dat_d    = bus.req_wdata;
              end
            endcase
          end else begin
            state_d      = S_READ;
            mem_r_enb_d  = 1'b1;
            mem_r_addr_d = bus.req_addr[RAM_ADDR_WIDTH-1:0];
            cnt_d        = 2'(RD_LAT);
          end
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_READ: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end else begin
          cnt_d       = cnt_q - 2'd1;
          mem_r_enb_d = 1'b1;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'd0;
          req_ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 2'd0;
      funct3_q       <= 3'd0;
      off_q          <= 2'd0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 32'd0;
      rsp_err_q      <= 1'b0;
      mem_w_addr_q   <= '0;
      mem_w_dat_q    <= 32'd0;
      mem_w_enb_q    <= 1'b0;
      mem_byte_enb_q <= 4'd0;
      mem_r_addr_q   <= '0;
      mem_r_enb_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      mem_w_addr_q   <= mem_w_addr_d;
      mem_w_dat_q    <= mem_w_dat_d;
      mem_w_enb_q    <= mem_w_enb_d;
      mem_byte_enb_q <= mem_byte_enb_d;
      mem_r_addr_q   <= mem_r_addr_d;
      mem_r_enb_q    <= mem_r_enb_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.mem_w_addr   = mem_w_addr_q;
  assign bus.mem_w_dat    = mem_w_dat_q;
  assign bus.mem_w_enb    = mem_w_enb_q;
  assign bus.mem_byte_enb = mem_byte_enb_q;
  assign bus.mem_r_addr   = mem_r_addr_q;
  assign bus.mem_r_enb    = mem_r_enb_q;

endmodule
